// File: rtl/radix4_mult_pkg.sv
// radix4_mult_pkg: shared FSM states, Booth select codes and window decode for radix4_multiplier
package radix4_mult_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {BOOTH_ZERO, BOOTH_POS1, BOOTH_POS2, BOOTH_NEG1, BOOTH_NEG2} booth_t;
  function automatic booth_t booth_sel(input logic [2:0] w);
    return (w == 3'b011) ? BOOTH_POS2 :
           (w == 3'b100) ? BOOTH_NEG2 :
           (w == 3'b001 || w == 3'b010) ? BOOTH_POS1 :
           (w == 3'b101 || w == 3'b110) ? BOOTH_NEG1 : BOOTH_ZERO;
  endfunction
endpackage

// File: rtl/radix4_multiplier_booth_encoder.sv
// booth_encoder: maps a 3-bit Booth window and the extended multiplicand to a signed partial product
module booth_encoder
  import radix4_mult_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   window,
  input  logic [W+1:0] a,
  output logic [W+2:0] pp
);
  booth_t sel;
  logic [W+2:0] ae;
  assign sel = booth_sel(window);
  assign ae = {a[W+1], a};
  // Choose 0, +-A or +-2A; one extra bit keeps 2A exact for the widest operand
  always_comb begin
    pp = sel == BOOTH_POS1 ? ae :
         sel == BOOTH_POS2 ? ae << 1 :
         sel == BOOTH_NEG1 ? -ae :
         sel == BOOTH_NEG2 ? -(ae << 1) : '0;
  end
endmodule

// File: rtl/radix4_multiplier.sv
// radix4_multiplier: multi-cycle radix-4 Booth multiplier, signed/unsigned, optional MULT_EARLY_TERM_EN early exit
module radix4_multiplier
  import radix4_mult_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  input  logic             signed_mode,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_busy,
  output logic             op_done,
  output logic [2*W-1:0]   result
);
  localparam int N = W / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * W + 6;
  state_t state;
  logic [CW-1:0] count;
  logic [W+1:0] a_reg;
  logic [AW-1:0] acc, shifted, fin_acc;
  logic [W+2:0] pp, sum;
  logic last, fin;
  function automatic logic [W+1:0] ext(input logic [W-1:0] v, input logic s);
    return {{2{s & v[W-1]}}, v};
  endfunction
  booth_encoder #(.W(W)) u_enc (.window(acc[2:0]), .a(a_reg), .pp(pp));
  assign sum = acc[AW-1 -: W+3] + pp;
  assign shifted = $signed({sum, acc[W+2:0]}) >>> 2;
  assign last = count == CW'(N - 1);
`ifdef MULT_EARLY_TERM_EN
  logic [W+1:0] b_reg, rest;
  assign rest = $signed(b_reg) >>> (2 * count + 1);
  assign fin = last || rest == '0 || &rest;
  assign fin_acc = $signed(shifted) >>> (2 * (N - 1 - count));
`else
  assign fin = last;
  assign fin_acc = shifted;
`endif
  // Control FSM with accumulator/shift register and registered outputs; clear beats any state action
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      a_reg <= '0;
      acc <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      result <= '0;
`ifdef MULT_EARLY_TERM_EN
      b_reg <= '0;
`endif
    end else if (op_clear) begin
      state <= S_IDLE;
      count <= '0;
      a_reg <= '0;
      acc <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      result <= '0;
`ifdef MULT_EARLY_TERM_EN
      b_reg <= '0;
`endif
    end else if (state == S_IDLE) begin
      if (op_start) begin
        state <= S_EXEC;
        count <= '0;
        a_reg <= ext(multiplicand, signed_mode);
        acc <= {{(W+3){1'b0}}, ext(multiplier, signed_mode), 1'b0};
        op_busy <= 1'b1;
`ifdef MULT_EARLY_TERM_EN
        b_reg <= ext(multiplier, signed_mode);
`endif
      end
    end else if (state == S_EXEC) begin
      if (fin) begin
        state <= S_DONE;
        acc <= fin_acc;
        op_busy <= 1'b0;
        op_done <= 1'b1;
        result <= fin_acc[2*W:1];
      end else begin
        acc <= shifted;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_radix4_multiplier.sv
// tb_radix4_multiplier: table-driven scoreboard bench for radix4_multiplier (W=32)
module tb_radix4_multiplier;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] multiplicand, multiplier;
  logic signed_mode, op_start, op_clear;
  logic op_busy, op_done;
  logic [63:0] result;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic sm;
    logic [63:0] exp;
  } vec_t;
  vec_t vt[12];
  radix4_multiplier #(.W(32)) dut (
    .clk(clk), .reset_n(reset_n), .multiplicand(multiplicand), .multiplier(multiplier),
    .signed_mode(signed_mode), .op_start(op_start), .op_clear(op_clear),
    .op_busy(op_busy), .op_done(op_done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    logic [63:0] ea, eb;
    ea = {{32{sm & a[31]}}, a};
    eb = {{32{sm & b[31]}}, b};
    return ea * eb;
  endfunction
  function automatic int exp_lat(input logic [31:0] b, input logic sm);
`ifdef MULT_EARLY_TERM_EN
    logic [33:0] be, r;
    be = {{2{sm & b[31]}}, b};
    for (int i = 1; i <= 17; i++) begin
      r = $signed(be) >>> (2 * i - 1);
      if (r == '0 || &r) return i;
    end
`endif
    return 17;
  endfunction
  task automatic clear_pulse(input string name);
    @(negedge clk);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    chk({name, "_clr_done"}, {63'b0, op_done}, 64'd0);
    chk({name, "_clr_result"}, result, 64'd0);
  endtask
  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b, input logic sm, input logic [63:0] exp);
    int cyc, busy_cnt, lat;
    lat = exp_lat(b, sm);
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    signed_mode = sm;
    op_start = 1'b1;
    sb.push_back(exp);
    tick();
    op_start = 1'b0;
    cyc = 0;
    busy_cnt = op_busy ? 1 : 0;
    while (!op_done && cyc < 40) begin
      tick();
      cyc++;
      if (op_busy) busy_cnt++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({name, "_result"}, result, sb.pop_front());
    clear_pulse(name);
  endtask
  initial begin
    int cyc;
    logic [31:0] ra, rb;
    logic rs;
    vt[0]  = '{32'd11, 32'hFFFF_FFF5, 1'b1, 64'hFFFF_FFFF_FFFF_FF87};
    vt[1]  = '{32'd6, 32'd6, 1'b1, 64'd36};
    vt[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vt[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1};
    vt[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vt[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
    vt[6]  = '{32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000};
    vt[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
    vt[8]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};
    vt[9]  = '{32'h1234_5678, 32'd0, 1'b0, 64'd0};
    vt[10] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 64'h0000_0000_FFFF_FFFF};
    vt[11] = '{32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    reset_n = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    signed_mode = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    tick();
    tick();
    chk("reset_busy", {63'b0, op_busy}, 64'd0);
    chk("reset_done", {63'b0, op_done}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) run($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sm, vt[i].exp);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'(i % 2);
      run($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
    end
    // start ignored mid-operation: new operands pulsed at edge 5
    @(negedge clk);
    multiplicand = 32'd11;
    multiplier = 32'hFFFF_FFF5;
    signed_mode = 1'b1;
    op_start = 1'b1;
    sb.push_back(64'hFFFF_FFFF_FFFF_FF87);
    tick();
    op_start = 1'b0;
    cyc = 0;
    while (!op_done && cyc < 40) begin
      if (cyc == 4) begin
        multiplicand = 32'd3;
        multiplier = 32'd5;
        signed_mode = 1'b0;
        op_start = 1'b1;
      end else op_start = 1'b0;
      tick();
      cyc++;
    end
    op_start = 1'b0;
    chk("restart_latency", 64'(cyc), 64'(exp_lat(32'hFFFF_FFF5, 1'b1)));
    chk("restart_result", result, sb.pop_front());
    clear_pulse("restart");
    chk("restart_idle_busy", {63'b0, op_busy}, 64'd0);
    // clear at edge 8 of EXEC aborts the operation
    @(negedge clk);
    multiplicand = 32'd12345;
    multiplier = 32'h8000_0001;
    signed_mode = 1'b0;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    clear_pulse("abort");
    chk("abort_busy", {63'b0, op_busy}, 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_done", {63'b0, op_done}, 64'd0);
    // start and clear together: no start; start held afterwards is accepted
    @(negedge clk);
    multiplicand = 32'd6;
    multiplier = 32'd6;
    signed_mode = 1'b1;
    op_start = 1'b1;
    op_clear = 1'b1;
    tick();
    chk("both_no_start", {63'b0, op_busy}, 64'd0);
    op_clear = 1'b0;
    sb.push_back(64'd36);
    tick();
    op_start = 1'b0;
    chk("held_start_busy", {63'b0, op_busy}, 64'd1);
    cyc = 0;
    while (!op_done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("held_latency", 64'(cyc), 64'(exp_lat(32'd6, 1'b1)));
    chk("held_result", result, sb.pop_front());
    clear_pulse("held");
    // asynchronous reset mid-EXEC
    @(negedge clk);
    multiplicand = 32'hDEAD_BEEF;
    multiplier = 32'hAAAA_AAAA;
    signed_mode = 1'b0;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, op_busy}, 64'd0);
    chk("arst_done", {63'b0, op_done}, 64'd0);
    chk("arst_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("arst_stays_idle", {62'b0, op_busy, op_done}, 64'd0);
    run("after_reset", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
